ss_fbdiv_mod: RTL and testbench
===============================

SS_FBDIV_MOD -- requirements
Module: ss_fbdiv_mod

Interface
- REQ-001: The block SHALL have parameter DIV_W, default 12, giving the width of the divider counter and reload value.
- REQ-002: The block SHALL have parameter DIVF, default 32, giving the nominal reload; the feedback period is reload+1 pll_clk cycles.
- REQ-003: The block SHALL have parameter SPAN, default 4, giving the maximum reload deviation, so reload ranges over DIVF-SPAN..DIVF+SPAN.
- REQ-004: The block SHALL have parameter UDIV, default 0, so that a modulation update occurs once per UDIV+1 feedback pulses.
- REQ-005: The block SHALL have parameter LFSR_W, default 19, giving the PRNG width.
- REQ-006: The block SHALL have parameter LFSR_POLY, default 19'h593CA, giving the Galois feedback mask.
- REQ-007: The block SHALL have parameter LFSR_SEED, default 1, giving the PRNG reset value; it shall be nonzero.
- REQ-008: Port pll_clk, input, 1 bit: sole clock of the block.
- REQ-009: Port pll_rst, input, 1 bit: reset, asynchronous, active-high; clock pll_clk.
- REQ-010: Port i_en, input, 1 bit: modulation enable; when 0, the block behaves as mode 0.
- REQ-011: Port i_mode, input, 2 bits: 0 = off, 1 = binary random, 2 = triangle, 3 = reserved (treated as 0).
- REQ-012: Port o_fb, output, 1 bit: feedback pulse for the PLL EXTFEEDBACK input.
- REQ-013: Port o_div, output, DIV_W bits: reload value currently in use.
- REQ-014: Port o_upd, output, 1 bit: marks an update event.

Function
- REQ-015: State SHALL be: cnt (DIV_W), ucnt (>=1 bit, counts UDIV..0), lfsr (LFSR_W), signed offset (range -SPAN..+SPAN), dir (up/down), and curr_div (drives o_div).
- REQ-016: o_fb SHALL equal (cnt==0), and o_upd SHALL equal (cnt==0 && ucnt==0); both are decoded from registers only, with no combinational path from any input.
- REQ-017: When cnt!=0, cnt SHALL decrement by 1 each cycle.
- REQ-018: When cnt==0 and ucnt!=0, cnt SHALL load curr_div, and ucnt SHALL decrement.
- REQ-019: When cnt==0 and ucnt==0 (update event), ucnt SHALL load UDIV, and offset_next SHALL be computed from the effective mode as in REQ-020..022.
- REQ-020: Effective mode 0 (off, mode 3, or i_en=0): offset_next=0 and dir<=up; lfsr holds.
- REQ-021: Mode 1: offset_next=+SPAN if the pre-step lfsr[0]=1, else -SPAN; lfsr steps as lfsr<=(lfsr>>1)^(lfsr[0]?LFSR_POLY:0).
- REQ-022: Mode 2 (triangle), lfsr holds:
  - dir up: if offset==SPAN, then dir<=down and offset_next=SPAN-1; otherwise offset_next=offset+1.
  - dir down: mirrored at -SPAN.
  - With SPAN=0, offset_next SHALL stay 0.
- REQ-023: At an update event, offset<=offset_next, and both curr_div and cnt SHALL load DIVF+offset_next in the same cycle.
- REQ-024: i_mode and i_en SHALL be sampled only at update events; the period in progress always completes unchanged.
- REQ-025: Reload arithmetic SHALL be done at DIV_W+1 bits signed; elaboration SHALL fail unless DIVF-SPAN>=1 and DIVF+SPAN<=2^DIV_W-1.
- REQ-026: i_en and i_mode SHALL be synchronous to pll_clk; any synchronisation is the caller's responsibility.

Reset
- REQ-027: While pll_rst=1, the block SHALL hold cnt=0, ucnt=0, lfsr=LFSR_SEED, offset=0, dir=up, curr_div=DIVF.
- REQ-028: While pll_rst=1, o_div=DIVF, o_fb=1 and o_upd=1; consumers SHALL ignore o_fb and o_upd during reset.
- REQ-029: Reset assertion SHALL take effect asynchronously, including mid-period.
- REQ-030: The first cycle after reset release SHALL be an update event.

Verification
All scenarios use DIVF=8, SPAN=2, UDIV=0 unless stated.
- REQ-031: Release reset with en=1, mode=0 -> o_fb high every 9 cycles starting at the first cycle; o_div constant at 8.
- REQ-032: mode=1, seed=1 -> o_div sequence 10, 6, 10, ...; periods 11, 7, 11 cycles; lfsr after two steps = 0x2C9E5.
- REQ-033: mode=2 -> o_div 9, 10, 9, 8, 7, 6, 7, 8, 9 over successive pulses; the triangle repeats every 8 updates.
- REQ-034: UDIV=2, mode=2 -> o_upd high on o_fb pulses 1, 4, 7; o_div changes only at those pulses (9, 10, 9).
- REQ-035: mode=2, switch to mode=0 (or drop i_en) mid-count -> the current period completes at its old length; the next reload is 8, offset=0, dir=up; returning to mode=2 restarts at 9.
- REQ-036: Assert pll_rst for 1 cycle mid-period in mode=1 -> outputs go to reset values immediately; after release, the o_div sequence restarts at 10.

Source files
------------

// File: rtl/ss_fbdiv_mod.sv
// ss_fbdiv_mod: spread-spectrum feedback divider; the reload is offset by a random or triangle modulation once per update interval.
module ss_fbdiv_mod #(
  parameter int                DIV_W     = 12,
  parameter int                DIVF      = 32,
  parameter int                SPAN      = 4,
  parameter int                UDIV      = 0,
  parameter int                LFSR_W    = 19,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 19'h593CA,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 1
) (
  input  logic             pll_clk,
  input  logic             pll_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  output logic             o_fb,
  output logic [DIV_W-1:0] o_div,
  output logic             o_upd
);
  localparam int UW = UDIV > 0 ? $clog2(UDIV + 1) : 1;
  typedef logic signed [DIV_W:0] s_t;
  localparam s_t SP = s_t'(SPAN);
  localparam s_t DV = s_t'(DIVF);
  if (DIVF - SPAN < 1 || DIVF + SPAN > 2 ** DIV_W - 1 || LFSR_SEED == '0) begin : g_bad_params
    $error("ss_fbdiv_mod: reload range or LFSR seed out of bounds");
  end
  logic [DIV_W-1:0]  cnt, curr_div, reload;
  logic [UW-1:0]     ucnt;
  logic [LFSR_W-1:0] lfsr, lfsr_nx;
  s_t                off, off_nx;
  logic              dn, dn_nx;
  logic [1:0]        mode;
  assign mode   = i_en && (i_mode == 2'd1 || i_mode == 2'd2) ? i_mode : 2'd0;
  assign o_fb   = cnt == '0;
  assign o_upd  = cnt == '0 && ucnt == '0;
  assign o_div  = curr_div;
  assign reload = DIV_W'(DV + off_nx);
  // triangle turns around when it sits at an end, so the step after a peak already heads back
  always_comb begin
    lfsr_nx = lfsr;
    dn_nx   = 1'b0;
    off_nx  = '0;
    if (mode == 2'd1) begin
      dn_nx   = dn;
      off_nx  = lfsr[0] ? SP : -SP;
      lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
    end else if (mode == 2'd2) begin
      dn_nx  = SPAN == 0 ? dn : dn ? off != -SP : off == SP;
      off_nx = SPAN == 0 ? '0 : dn_nx ? off - 1'b1 : off + 1'b1;
    end
  end
  always_ff @(posedge pll_clk or posedge pll_rst) begin
    if (pll_rst) begin
      cnt      <= '0;
      ucnt     <= '0;
      lfsr     <= LFSR_SEED;
      off      <= '0;
      dn       <= 1'b0;
      curr_div <= DIV_W'(DIVF);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (ucnt != '0) begin
      cnt  <= curr_div;
      ucnt <= ucnt - 1'b1;
    end else begin
      cnt      <= reload;
      curr_div <= reload;
      ucnt     <= UW'(UDIV);
      off      <= off_nx;
      dn       <= dn_nx;
      lfsr     <= lfsr_nx;
    end
  end
endmodule

// File: tb/tb_ss_fbdiv_mod.sv
// tb_ss_fbdiv_mod: two divider instances (UDIV=0 and UDIV=2) checked every cycle against an event-time model.
module tb_ss_fbdiv_mod;
  localparam int DIVF = 8;
  localparam int SPAN = 2;
  localparam int UD[2] = '{0, 2};
  localparam logic [18:0] POLY = 19'h593CA;
  logic        pll_clk = 1'b0;
  logic        pll_rst = 1'b1;
  logic        i_en = 1'b1;
  logic [1:0]  i_mode = 2'd0;
  logic        fb [2];
  logic        upd [2];
  logic [11:0] dv [2];
  int n_chk = 0, n_pass = 0;
  int t;
  int m_nxt [2], m_idx [2], m_div [2], m_off [2];
  bit m_dn [2];
  logic [18:0] m_lfsr [2];
  int qd [2][$];
  ss_fbdiv_mod #(.DIVF(DIVF), .SPAN(SPAN), .UDIV(0)) u0 (
    .pll_clk(pll_clk), .pll_rst(pll_rst), .i_en(i_en), .i_mode(i_mode),
    .o_fb(fb[0]), .o_div(dv[0]), .o_upd(upd[0]));
  ss_fbdiv_mod #(.DIVF(DIVF), .SPAN(SPAN), .UDIV(2)) u1 (
    .pll_clk(pll_clk), .pll_rst(pll_rst), .i_en(i_en), .i_mode(i_mode),
    .o_fb(fb[1]), .o_div(dv[1]), .o_upd(upd[1]));
  always #5 pll_clk = ~pll_clk;
  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask
  function automatic int tri_off(int k);
    return k <= SPAN ? k : k <= 3 * SPAN ? 2 * SPAN - k : k - 4 * SPAN;
  endfunction
  task automatic m_init();
    t = 0;
    for (int i = 0; i < 2; i++) begin
      m_nxt[i] = 0; m_idx[i] = 0; m_div[i] = DIVF; m_off[i] = 0;
      m_dn[i] = 0; m_lfsr[i] = 19'd1; qd[i].delete();
    end
  endtask
  task automatic m_update(int i);
    int md, k;
    md = (i_en && (i_mode == 1 || i_mode == 2)) ? int'(i_mode) : 0;
    if (md == 0) begin
      m_off[i] = 0; m_dn[i] = 0;
    end else if (md == 1) begin
      m_off[i] = m_lfsr[i][0] ? SPAN : -SPAN;
      m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? POLY : 19'd0);
    end else begin
      k = !m_dn[i] ? (m_off[i] >= 0 ? m_off[i] : 4 * SPAN + m_off[i]) : 2 * SPAN - m_off[i];
      k = (k + 1) % (4 * SPAN);
      m_off[i] = tri_off(k);
      m_dn[i] = k > SPAN && k <= 3 * SPAN;
    end
    m_div[i] = DIVF + m_off[i];
  endtask
  task automatic cycle();
    for (int i = 0; i < 2; i++) begin
      bit p;
      p = (t == m_nxt[i]);
      chk($sformatf("fb%0d", i), int'(fb[i]), int'(p));
      chk($sformatf("upd%0d", i), int'(upd[i]), int'(p && m_idx[i] == 0));
      chk($sformatf("div%0d", i), int'(dv[i]), m_div[i]);
      if (p) qd[i].push_back(int'(dv[i]));
    end
  endtask
  task automatic step();
    for (int i = 0; i < 2; i++)
      if (t == m_nxt[i]) begin
        if (m_idx[i] == 0) m_update(i);
        m_nxt[i] = t + m_div[i] + 1;
        m_idx[i] = (m_idx[i] + 1) % (UD[i] + 1);
      end
    t++;
  endtask
  task automatic run(int n, bit rnd);
    repeat (n) begin
      @(negedge pll_clk);
      cycle();
      if (rnd && $urandom_range(0, 11) == 0) i_mode = 2'($urandom_range(0, 3));
      if (rnd && $urandom_range(0, 39) == 0) i_en = $urandom_range(0, 5) != 0;
      step();
    end
  endtask
  task automatic chk_rst(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_fb%0d", tag, i), int'(fb[i]), 1);
      chk($sformatf("%s_upd%0d", tag, i), int'(upd[i]), 1);
      chk($sformatf("%s_div%0d", tag, i), int'(dv[i]), DIVF);
    end
  endtask
  // reset is raised between edges so the outputs must change without a clock
  task automatic rst_async();
    @(posedge pll_clk);
    #3 pll_rst = 1'b1;
    #1 chk_rst("rst_async");
    @(negedge pll_clk);
    chk_rst("rst_hold");
    pll_rst = 1'b0;
    m_init();
    cycle();
    step();
  endtask
  task automatic chk_seq(string tag, int i, int exp[]);
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s%0d", tag, k), k + 1 < qd[i].size() ? qd[i][k + 1] : -1, exp[k]);
  endtask
  initial begin
    m_init();
    i_en = 1'b1; i_mode = 2'd0;
    rst_async();
    run(45, 0);
    chk_seq("off_div", 0, '{8, 8, 8, 8});
    i_mode = 2'd1;
    rst_async();
    run(40, 0);
    chk_seq("rnd_div", 0, '{10, 6, 10});
    i_mode = 2'd2;
    rst_async();
    run(100, 0);
    chk_seq("tri_div", 0, '{9, 10, 9, 8, 7, 6, 7, 8, 9});
    chk_seq("udiv_div", 1, '{9, 9, 9, 10, 10, 10, 9});
    i_mode = 2'd2;
    rst_async();
    run(25, 0);
    i_mode = 2'd0;
    run(30, 0);
    i_en = 1'b0; i_mode = 2'd2;
    run(20, 0);
    i_en = 1'b1;
    run(40, 0);
    i_mode = 2'd1;
    run(37, 0);
    rst_async();
    run(60, 0);
    chk_seq("rst_rnd_div", 0, '{10, 6, 10});
    for (int r = 0; r < 4; r++) begin
      run(600, 1);
      rst_async();
    end
    run(300, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
